fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, byte-address width.
REQ-002 SHALL have parameter RESET_PC, default 24'h000000, fetch address after reset.
REQ-003 SHALL have ports clk (in, 1, sole clock) and reset (in, 1, synchronous, active-high).
REQ-004 SHALL have bus ports: bus_req out 1; bus_addr out ADDR_W; bus_ack in 1 (data valid this cycle); bus_data_in in 8.
REQ-005 SHALL have decoder ports: dec_opcode out 8; dec_opext out 8; dec_need_opext in 1; dec_need_imm in 1; dec_imm_size in 1 (0=8-bit, 1=16-bit).
REQ-006 SHALL have issue ports: insn_valid out 1; insn_ready in 1; insn_opcode out 8; insn_opext out 8; insn_imm out 16; insn_len out 3; insn_pc out ADDR_W.
REQ-007 SHALL have redirect ports: branch_valid in 1; branch_target in ADDR_W.

Function
REQ-008 SHALL implement states FETCH_OP, FETCH_EXT, FETCH_IMM_LO, FETCH_IMM_HI, ISSUE.
REQ-009 SHALL assert bus_req in every FETCH_* state, holding bus_addr stable until bus_ack.
REQ-010 SHALL drive dec_opcode from bus_data_in in FETCH_OP, else from the opcode register; dec_opext likewise in FETCH_EXT.
REQ-011 FETCH_OP on ack SHALL capture opcode, then go to FETCH_EXT if dec_need_opext, else FETCH_IMM_LO if dec_need_imm, else ISSUE.
REQ-012 FETCH_EXT on ack SHALL capture opext, then go to FETCH_IMM_LO if dec_need_imm, else ISSUE.
REQ-013 FETCH_IMM_LO on ack SHALL capture imm[7:0], then go to FETCH_IMM_HI if imm_size latched 1, else ISSUE with imm[15:8]=0.
REQ-014 FETCH_IMM_HI on ack SHALL capture imm[15:8] and go to ISSUE.
REQ-015 Fetch address SHALL increment by 1 per acked byte, wrapping modulo 2^ADDR_W.
REQ-016 ISSUE SHALL assert insn_valid with all insn_* fields stable until insn_ready; insn_len = 1+opext+imm bytes (1..4); insn_pc = address of opcode byte.
REQ-017 On insn_valid&&insn_ready SHALL return to FETCH_OP at next byte address; unused opext field SHALL read 0.
REQ-018 Best-case latency: opcode acked cycle N SHALL give insn_valid in cycle N+1 for a 1-byte instruction.
REQ-019 branch_valid in any state SHALL abort the current fetch, drop bus_req and insn_valid next cycle, load branch_target, enter FETCH_OP.
REQ-020 bus_ack coincident with branch_valid SHALL have its data discarded; branch wins.
REQ-021 insn_ready coincident with branch_valid in ISSUE SHALL count as accepted and then redirect.
REQ-022 bus_ack outside FETCH_* states SHALL be ignored.

Reset
REQ-023 Reset SHALL force FETCH_OP, fetch address RESET_PC, bus_req=0, insn_valid=0, all captured fields and insn_* outputs 0, prefetch buffer empty.
REQ-024 bus_req SHALL first assert in the cycle after reset deasserts; reset mid-fetch SHALL discard partial instruction.

Configuration
REQ-025 With FETCH_PREFETCH_EN defined, ISSUE SHALL read byte at next address into a one-byte buffer while insn_valid is stalled; FETCH_OP SHALL consume a full buffer with no bus cycle.
REQ-026 Prefetch buffer SHALL be invalidated on branch_valid and reset; without the macro no buffer exists and bus_req is 0 in ISSUE.

Structure
REQ-027 State enum, insn_len encoding and RESET_PC default SHALL live in shared package fetch_pkg.
REQ-028 Prefetch buffer SHALL be sub-module prefetch_buf (valid, data, addr, load, consume, flush), instantiated only under FETCH_PREFETCH_EN.

Verification
REQ-029 Reset, RESET_PC=0, byte 8'h00 (1-byte) acked at once -> insn_valid next cycle, insn_len=1, insn_pc=0, next bus_addr=1.
REQ-030 Opcode 8'hCE, opext 8'h44, decoder need_imm=1,size=1, imm bytes 34,12 -> insn_opext=44, insn_imm=16'h1234, insn_len=4.
REQ-031 insn_ready held 0 for 5 cycles -> insn_* stable, bus_req=0 (or single prefetch with macro), then accept -> FETCH_OP.
REQ-032 branch_valid to 24'h002100 during FETCH_IMM_LO with simultaneous ack -> data dropped, next bus_addr=24'h002100.
REQ-033 Fetch at 24'hFFFFFF of 2-byte insn -> second byte address 24'h000000, insn_pc=24'hFFFFFF.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the byte-serial instruction fetch sequencer:
//   - fetch_state_t : sequencer state encoding
//   - insn_len_t    : instruction length in bytes (1..4, 0 only after reset)
//   - RESET_PC_DEFAULT : default fetch address after reset
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [2:0] {
        FETCH_OP     = 3'd0,
        FETCH_EXT    = 3'd1,
        FETCH_IMM_LO = 3'd2,
        FETCH_IMM_HI = 3'd3,
        ISSUE        = 3'd4
    } fetch_state_t;

    // Length counts acknowledged bytes of the instruction being assembled.
    typedef logic [2:0] insn_len_t;

    localparam insn_len_t LEN_NONE   = 3'd0;
    localparam insn_len_t LEN_OPCODE = 3'd1;
    localparam insn_len_t LEN_MAX    = 3'd4;

    localparam logic [23:0] RESET_PC_DEFAULT = 24'h000000;

    // One more byte appended to the instruction; saturates at the longest form.
    function automatic insn_len_t len_add_byte(input insn_len_t len);
        return (len >= LEN_MAX) ? LEN_MAX : len + 3'd1;
    endfunction

endpackage

// File: rtl/prefetch_buf.sv
// -----------------------------------------------------------------------------
// prefetch_buf
// One-byte prefetch buffer holding the byte at the address following the
// instruction currently waiting in ISSUE. Only built when FETCH_PREFETCH_EN
// is defined.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   load              : capture load_data/load_addr, mark valid
//   consume           : byte used by the sequencer, mark empty
//   flush             : discard contents (redirect)
//   load_data/addr    : byte and its address being captured
//   valid, data, addr : buffer state
// -----------------------------------------------------------------------------
module prefetch_buf #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              consume,
    input  logic              flush,
    input  logic [7:0]        load_data,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              valid,
    output logic [7:0]        data,
    output logic [ADDR_W-1:0] addr
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

    // NOTE: the payload is cleared on reset only so it never reads X; 'valid'
    // alone decides whether it is meaningful, so flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= 8'h00;
            addr <= '0;
        end else if (load) begin
            data <= load_data;
            addr <= load_addr;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Byte-serial instruction fetch: reads an opcode, an optional opcode
// extension byte and an optional 8/16-bit little-endian immediate from a
// byte bus, then presents the assembled instruction on a valid/ready port.
// A branch redirect aborts whatever is in flight.
//
// Optional feature macro: FETCH_PREFETCH_EN -- while an instruction waits in
// ISSUE, the byte at the next address is read into a one-byte buffer and
// FETCH_OP then consumes it without a bus cycle.
//
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   bus_req/bus_addr            : byte read request, address held until ack
//   bus_ack/bus_data_in         : read data valid this cycle
//   dec_opcode/dec_opext        : bytes presented to the external decoder
//   dec_need_opext/need_imm/imm_size : decoder answers
//   insn_valid/insn_ready       : issue handshake
//   insn_opcode/opext/imm/len/pc: assembled instruction
//   branch_valid/branch_target  : redirect request
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 24,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    // byte bus
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic [7:0]        bus_data_in,
    // decoder
    output logic [7:0]        dec_opcode,
    output logic [7:0]        dec_opext,
    input  logic              dec_need_opext,
    input  logic              dec_need_imm,
    input  logic              dec_imm_size,
    // issue
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic [7:0]        insn_opcode,
    output logic [7:0]        insn_opext,
    output logic [15:0]       insn_imm,
    output logic [2:0]        insn_len,
    output logic [ADDR_W-1:0] insn_pc,
    // redirect
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target
);

    fetch_state_t      state, next_state;
    logic [ADDR_W-1:0] fetch_addr;    // address of the next byte to obtain
    logic [ADDR_W-1:0] pc_q;          // address of the current opcode byte
    logic [7:0]        opcode_q;
    logic [7:0]        opext_q;
    logic [15:0]       imm_q;
    insn_len_t         len_q;
    logic              imm_size_q;
    // Set for one cycle after reset or a redirect so the bus sees a clean
    // idle cycle before the first request from the new address.
    logic              quiet;

    logic              pf_hit;
    logic [7:0]        pf_data;
    logic [7:0]        byte_in;
    logic              fetch_ack;

    // -------------------------------------------------------------------------
    // Optional prefetch buffer
    // -------------------------------------------------------------------------
`ifdef FETCH_PREFETCH_EN
    logic              pf_valid;
    logic [ADDR_W-1:0] pf_addr;
    logic              pf_load;
    logic              pf_consume;

    assign pf_hit     = pf_valid && (pf_addr == fetch_addr) && (state == FETCH_OP);
    assign pf_load    = (state == ISSUE) && bus_req && bus_ack && !branch_valid;
    assign pf_consume = pf_hit && !branch_valid;

    prefetch_buf #(
        .ADDR_W(ADDR_W)
    ) u_prefetch_buf (
        .clk      (clk),
        .reset    (reset),
        .load     (pf_load),
        .consume  (pf_consume),
        .flush    (branch_valid),
        .load_data(bus_data_in),
        .load_addr(fetch_addr),
        .valid    (pf_valid),
        .data     (pf_data),
        .addr     (pf_addr)
    );
`else
    assign pf_hit  = 1'b0;
    assign pf_data = 8'h00;
`endif

    // -------------------------------------------------------------------------
    // Bus request and byte source
    // -------------------------------------------------------------------------
    always_comb begin
        bus_req = 1'b0;
        if (!quiet) begin
            case (state)
                FETCH_OP:                            bus_req = !pf_hit;
                FETCH_EXT, FETCH_IMM_LO, FETCH_IMM_HI: bus_req = 1'b1;
`ifdef FETCH_PREFETCH_EN
                ISSUE:                               bus_req = !pf_valid;
`endif
                default:                             bus_req = 1'b0;
            endcase
        end
    end

    assign bus_addr  = fetch_addr;
    assign byte_in   = pf_hit ? pf_data : bus_data_in;
    // A byte for the instruction under assembly; ISSUE acks only feed the buffer.
    assign fetch_ack = (state != ISSUE) && (pf_hit || (bus_req && bus_ack));

    assign dec_opcode = (state == FETCH_OP)  ? byte_in     : opcode_q;
    assign dec_opext  = (state == FETCH_EXT) ? bus_data_in : opext_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        if (branch_valid) begin
            next_state = FETCH_OP;
        end else begin
            case (state)
                FETCH_OP: begin
                    if (fetch_ack) begin
                        if (dec_need_opext)    next_state = FETCH_EXT;
                        else if (dec_need_imm) next_state = FETCH_IMM_LO;
                        else                   next_state = ISSUE;
                    end
                end
                FETCH_EXT: begin
                    if (fetch_ack) begin
                        next_state = dec_need_imm ? FETCH_IMM_LO : ISSUE;
                    end
                end
                FETCH_IMM_LO: begin
                    if (fetch_ack) begin
                        next_state = imm_size_q ? FETCH_IMM_HI : ISSUE;
                    end
                end
                FETCH_IMM_HI: begin
                    if (fetch_ack) next_state = ISSUE;
                end
                ISSUE: begin
                    if (insn_ready) next_state = FETCH_OP;
                end
                default: next_state = FETCH_OP;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register and datapath
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH_OP;
            quiet      <= 1'b1;
            fetch_addr <= RESET_PC;
            pc_q       <= '0;
            opcode_q   <= 8'h00;
            opext_q    <= 8'h00;
            imm_q      <= 16'h0000;
            len_q      <= LEN_NONE;
            imm_size_q <= 1'b0;
        end else begin
            state <= next_state;
            quiet <= branch_valid;
            if (branch_valid) begin
                // Any byte acked in this cycle is dropped.
                fetch_addr <= branch_target;
            end else if (fetch_ack) begin
                fetch_addr <= fetch_addr + ADDR_W'(1);
                case (state)
                    FETCH_OP: begin
                        pc_q       <= fetch_addr;
                        opcode_q   <= byte_in;
                        opext_q    <= 8'h00;
                        imm_q      <= 16'h0000;
                        len_q      <= LEN_OPCODE;
                        imm_size_q <= dec_imm_size;
                    end
                    FETCH_EXT: begin
                        opext_q    <= bus_data_in;
                        len_q      <= len_add_byte(len_q);
                        // The extension can change the immediate form.
                        imm_size_q <= dec_imm_size;
                    end
                    FETCH_IMM_LO: begin
                        imm_q <= {8'h00, bus_data_in};
                        len_q <= len_add_byte(len_q);
                    end
                    FETCH_IMM_HI: begin
                        imm_q[15:8] <= bus_data_in;
                        len_q       <= len_add_byte(len_q);
                    end
                    default: ;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Issue port
    // -------------------------------------------------------------------------
    assign insn_valid  = (state == ISSUE);
    assign insn_opcode = opcode_q;
    assign insn_opext  = opext_q;
    assign insn_imm    = imm_q;
    assign insn_len    = len_q;
    assign insn_pc     = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer (default build, prefetch disabled).
// Inputs change 1 ns after a rising edge; outputs are compared 1 ns later,
// well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int ADDR_W = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_ack;
    logic [7:0]        bus_data_in;
    logic [7:0]        dec_opcode;
    logic [7:0]        dec_opext;
    logic              dec_need_opext;
    logic              dec_need_imm;
    logic              dec_imm_size;
    logic              insn_valid;
    logic              insn_ready;
    logic [7:0]        insn_opcode;
    logic [7:0]        insn_opext;
    logic [15:0]       insn_imm;
    logic [2:0]        insn_len;
    logic [ADDR_W-1:0] insn_pc;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_target;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_sequencer #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(24'h000000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_req       (bus_req),
        .bus_addr      (bus_addr),
        .bus_ack       (bus_ack),
        .bus_data_in   (bus_data_in),
        .dec_opcode    (dec_opcode),
        .dec_opext     (dec_opext),
        .dec_need_opext(dec_need_opext),
        .dec_need_imm  (dec_need_imm),
        .dec_imm_size  (dec_imm_size),
        .insn_valid    (insn_valid),
        .insn_ready    (insn_ready),
        .insn_opcode   (insn_opcode),
        .insn_opext    (insn_opext),
        .insn_imm      (insn_imm),
        .insn_len      (insn_len),
        .insn_pc       (insn_pc),
        .branch_valid  (branch_valid),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    // Advance one clock; return 1 ns after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_ack        = 1'b0;
        bus_data_in    = 8'h00;
        dec_need_opext = 1'b0;
        dec_need_imm   = 1'b0;
        dec_imm_size   = 1'b0;
        insn_ready     = 1'b0;
        branch_valid   = 1'b0;
        branch_target  = '0;
    endtask

    // Present one acked byte together with the decoder answers for it.
    task automatic ack_byte(input logic [7:0] d, input logic opx, input logic imm, input logic sz);
        bus_ack        = 1'b1;
        bus_data_in    = d;
        dec_need_opext = opx;
        dec_need_imm   = imm;
        dec_imm_size   = sz;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        cycle();
        #1;
        n_checks++;
        if ({bus_req, insn_valid, insn_len, insn_pc, insn_opcode, insn_opext, insn_imm, bus_addr}
            !== {1'b0, 1'b0, 3'd0, 24'h0, 8'h00, 8'h00, 16'h0000, 24'h0})
            $display("FAIL reset_state: req=%b valid=%b len=%0d pc=%h op=%h ext=%h imm=%h addr=%h expected all zero",
                     bus_req, insn_valid, insn_len, insn_pc, insn_opcode, insn_opext, insn_imm, bus_addr);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus_req !== 1'b0) $display("FAIL req_in_release_cycle: got %b expected 0", bus_req);
        else n_pass++;
        cycle();
        n_checks++;
        if ({bus_req, bus_addr} !== {1'b1, 24'h000000})
            $display("FAIL first_req: req=%b addr=%h expected 1/000000", bus_req, bus_addr);
        else n_pass++;
    endtask

    // 1-byte instruction acked immediately: issued the very next cycle.
    task automatic test_single_byte();
        ack_byte(8'h00, 1'b0, 1'b0, 1'b0);
        cycle();
        idle_inputs();
        #1;
        n_checks++;
        if ({insn_valid, insn_len, insn_pc, insn_opcode, insn_opext, insn_imm, bus_req}
            !== {1'b1, 3'd1, 24'h000000, 8'h00, 8'h00, 16'h0000, 1'b0})
            $display("FAIL single_byte_issue: valid=%b len=%0d pc=%h op=%h ext=%h imm=%h req=%b expected 1/1/000000/00/00/0000/0",
                     insn_valid, insn_len, insn_pc, insn_opcode, insn_opext, insn_imm, bus_req);
        else n_pass++;
        insn_ready = 1'b1;
        cycle();
        insn_ready = 1'b0;
        #1;
        n_checks++;
        if ({insn_valid, bus_req, bus_addr} !== {1'b0, 1'b1, 24'h000001})
            $display("FAIL single_byte_next: valid=%b req=%b addr=%h expected 0/1/000001",
                     insn_valid, bus_req, bus_addr);
        else n_pass++;
    endtask

    // 4-byte instruction CE 44 34 12 at address 1, then a 5-cycle stall.
    task automatic test_full_insn_and_stall();
        ack_byte(8'hCE, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (dec_opcode !== 8'hCE) $display("FAIL dec_opcode_live: got %h expected ce", dec_opcode);
        else n_pass++;
        cycle();
        ack_byte(8'h44, 1'b0, 1'b1, 1'b1);
        #1;
        n_checks++;
        if ({bus_req, bus_addr, dec_opext, dec_opcode} !== {1'b1, 24'h000002, 8'h44, 8'hCE})
            $display("FAIL ext_phase: req=%b addr=%h dec_opext=%h dec_opcode=%h expected 1/000002/44/ce",
                     bus_req, bus_addr, dec_opext, dec_opcode);
        else n_pass++;
        cycle();
        // Decoder answers now change; the latched 16-bit size must still hold.
        ack_byte(8'h34, 1'b0, 1'b0, 1'b0);
        cycle();
        ack_byte(8'h12, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if ({bus_req, bus_addr} !== {1'b1, 24'h000004})
            $display("FAIL imm_hi_addr: req=%b addr=%h expected 1/000004", bus_req, bus_addr);
        else n_pass++;
        cycle();
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            // Acks while in ISSUE must be ignored.
            bus_ack     = 1'b1;
            bus_data_in = 8'hEE;
            #1;
            n_checks++;
            if ({insn_valid, insn_opcode, insn_opext, insn_imm, insn_len, insn_pc, bus_req}
                !== {1'b1, 8'hCE, 8'h44, 16'h1234, 3'd4, 24'h000001, 1'b0})
                $display("FAIL stall_cycle_%0d: valid=%b op=%h ext=%h imm=%h len=%0d pc=%h req=%b expected 1/ce/44/1234/4/000001/0",
                         i, insn_valid, insn_opcode, insn_opext, insn_imm, insn_len, insn_pc, bus_req);
            else n_pass++;
            if (i < 5) cycle();
        end
        idle_inputs();
        insn_ready = 1'b1;
        cycle();
        insn_ready = 1'b0;
        #1;
        n_checks++;
        if ({insn_valid, bus_req, bus_addr} !== {1'b0, 1'b1, 24'h000005})
            $display("FAIL after_stall_accept: valid=%b req=%b addr=%h expected 0/1/000005",
                     insn_valid, bus_req, bus_addr);
        else n_pass++;
    endtask

    // Wait states on the bus, then an 8-bit immediate instruction 10 AB.
    task automatic test_imm8_wait_states();
        cycle();
        cycle();
        n_checks++;
        if ({bus_req, bus_addr} !== {1'b1, 24'h000005})
            $display("FAIL wait_state_hold: req=%b addr=%h expected 1/000005", bus_req, bus_addr);
        else n_pass++;
        ack_byte(8'h10, 1'b0, 1'b1, 1'b0);
        cycle();
        ack_byte(8'hAB, 1'b0, 1'b0, 1'b0);
        cycle();
        idle_inputs();
        #1;
        n_checks++;
        if ({insn_valid, insn_opcode, insn_opext, insn_imm, insn_len, insn_pc}
            !== {1'b1, 8'h10, 8'h00, 16'h00AB, 3'd2, 24'h000005})
            $display("FAIL imm8_issue: valid=%b op=%h ext=%h imm=%h len=%0d pc=%h expected 1/10/00/00ab/2/000005",
                     insn_valid, insn_opcode, insn_opext, insn_imm, insn_len, insn_pc);
        else n_pass++;
        insn_ready = 1'b1;
        cycle();
        insn_ready = 1'b0;
    endtask

    // Redirect during FETCH_IMM_LO with a simultaneous ack, then in ISSUE.
    task automatic test_branch();
        ack_byte(8'h20, 1'b0, 1'b1, 1'b1);
        cycle();
        ack_byte(8'h55, 1'b0, 1'b0, 1'b0);
        branch_valid  = 1'b1;
        branch_target = 24'h002100;
        cycle();
        idle_inputs();
        #1;
        n_checks++;
        if ({bus_req, insn_valid, bus_addr} !== {1'b0, 1'b0, 24'h002100})
            $display("FAIL branch_drop: req=%b valid=%b addr=%h expected 0/0/002100",
                     bus_req, insn_valid, bus_addr);
        else n_pass++;
        cycle();
        n_checks++;
        if ({bus_req, bus_addr} !== {1'b1, 24'h002100})
            $display("FAIL branch_refetch: req=%b addr=%h expected 1/002100", bus_req, bus_addr);
        else n_pass++;
        ack_byte(8'h01, 1'b0, 1'b0, 1'b0);
        cycle();
        idle_inputs();
        #1;
        n_checks++;
        if ({insn_valid, insn_opcode, insn_imm, insn_len, insn_pc}
            !== {1'b1, 8'h01, 16'h0000, 3'd1, 24'h002100})
            $display("FAIL branch_target_issue: valid=%b op=%h imm=%h len=%0d pc=%h expected 1/01/0000/1/002100",
                     insn_valid, insn_opcode, insn_imm, insn_len, insn_pc);
        else n_pass++;
        insn_ready    = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 24'hFFFFFF;
        cycle();
        idle_inputs();
        #1;
        n_checks++;
        if ({insn_valid, bus_req, bus_addr} !== {1'b0, 1'b0, 24'hFFFFFF})
            $display("FAIL branch_in_issue: valid=%b req=%b addr=%h expected 0/0/ffffff",
                     insn_valid, bus_req, bus_addr);
        else n_pass++;
        cycle();
    endtask

    // 2-byte instruction starting at the top of the address space.
    task automatic test_wrap();
        ack_byte(8'h30, 1'b0, 1'b1, 1'b0);
        cycle();
        ack_byte(8'h7E, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if ({bus_req, bus_addr} !== {1'b1, 24'h000000})
            $display("FAIL wrap_addr: req=%b addr=%h expected 1/000000", bus_req, bus_addr);
        else n_pass++;
        cycle();
        idle_inputs();
        #1;
        n_checks++;
        if ({insn_valid, insn_pc, insn_len, insn_imm} !== {1'b1, 24'hFFFFFF, 3'd2, 16'h007E})
            $display("FAIL wrap_issue: valid=%b pc=%h len=%0d imm=%h expected 1/ffffff/2/007e",
                     insn_valid, insn_pc, insn_len, insn_imm);
        else n_pass++;
        insn_ready = 1'b1;
        cycle();
        insn_ready = 1'b0;
        #1;
        n_checks++;
        if (bus_addr !== 24'h000001) $display("FAIL wrap_next: addr=%h expected 000001", bus_addr);
        else n_pass++;
    endtask

    // Reset in the middle of an instruction discards it.
    task automatic test_reset_midfetch();
        ack_byte(8'h40, 1'b1, 1'b0, 1'b0);
        cycle();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus_req, insn_valid, insn_opcode, insn_len, bus_addr, dec_opcode}
            !== {1'b0, 1'b0, 8'h00, 3'd0, 24'h000000, 8'h00})
            $display("FAIL midfetch_reset: req=%b valid=%b op=%h len=%0d addr=%h dec_op=%h expected 0/0/00/0/000000/00",
                     bus_req, insn_valid, insn_opcode, insn_len, bus_addr, dec_opcode);
        else n_pass++;
        cycle();
        n_checks++;
        if ({bus_req, bus_addr} !== {1'b1, 24'h000000})
            $display("FAIL midfetch_restart: req=%b addr=%h expected 1/000000", bus_req, bus_addr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_full_insn_and_stall();
        test_imm8_wait_states();
        test_branch();
        test_wrap();
        test_reset_midfetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
